// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex-to-segment table
// (active-low, bit7 = dp, bits 6..0 = g..a) and the all-off pattern.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Index 15 is listed first: F, E, d, C, b, A, 9 .. 0
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low g..a segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_HEX[hex_i][6:0];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver. A prescaler divides clk into digit
// slots; the digit index steps once per slot. digits/dp are snapshotted into
// shadow registers at each frame boundary so a frame never tears. Anodes are
// blanked for the first BLANK_CYC counts of every slot to suppress ghosting.
// Optional build macro: SEG7_LZ_BLANK_EN (leading-zero blanking).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]           cnt_q,  cnt_d;
  logic [IW-1:0]           idx_q,  idx_d;
  logic [4*NUM_DIGITS-1:0] sdig_q, sdig_d;
  logic [NUM_DIGITS-1:0]   sdp_q,  sdp_d;
  logic                    pend_q, pend_d;
  logic [7:0]              seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q,  an_n_d;

  logic       tick, wrap;
  logic [3:0] nib;
  logic [6:0] seg7, seg7_shown;

  assign tick = en && (cnt_q == CW'(DIV - 1));
  assign wrap = tick && (idx_q == IW'(NUM_DIGITS - 1));

  // Next-state for prescaler, index and shadows; everything holds while en is low
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    sdig_d = sdig_q;
    sdp_d  = sdp_q;
    pend_d = pend_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
      if (wrap || pend_q) begin
        sdig_d = digits;
        sdp_d  = dp;
        pend_d = 1'b0;
      end
    end
  end

  // Outputs are decoded from next-state values so the registered seg_n/an_n
  // line up with the prescaler/index they describe.
  assign nib = sdig_d[{idx_d, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .hex_i   (nib),
    .seg_n_o (seg7)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic lz_blank;
  // Blank digit idx>0 when it and every higher shadow nibble are zero
  assign lz_blank   = (idx_d != '0) && ((sdig_d >> {idx_d, 2'b00}) == '0);
  assign seg7_shown = lz_blank ? 7'h7F : seg7;
`else
  assign seg7_shown = seg7;
`endif

  // Output pattern: dark when disabled, anodes dark during the blank window
  always_comb begin
    seg_n_d = SEG_OFF;
    an_n_d  = '1;
    if (en) begin
      seg_n_d = {~sdp_d[idx_d], seg7_shown};
      if (cnt_d >= CW'(BLANK_CYC))
        an_n_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      sdig_q  <= '0;
      sdp_q   <= '0;
      pend_q  <= 1'b1;
      seg_n_q <= SEG_OFF;
      an_n_q  <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sdig_q  <= sdig_d;
      sdp_q   <= sdp_d;
      pend_q  <= pend_d;
      seg_n_q <= seg_n_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = wrap && !rst;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (NUM_DIGITS=4, DIV=4, BLANK_CYC=1).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .DIV(4), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .dp         (dp),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected anodes for edges 1..16 of a frame that starts at count 0, digit 0
  logic [3:0] an_tab [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                              4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one 16-clock frame; e0..e3 are hand-computed seg_n per digit slot.
  // At edge chg_at (0 = never) digits/dp are changed to exercise shadowing.
  task automatic run_frame(input int fr, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input int chg_at,
                           input logic [15:0] chg_dig, input logic [3:0] chg_dp);
    logic [7:0] ev [4];
    ev = '{e0, e1, e2, e3};
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("an f%0d e%0d", fr, i), an_n, an_tab[i-1]);
      if (an_tab[i-1] != 4'hF)
        chk($sformatf("seg f%0d e%0d", fr, i), seg_n, ev[(i/4)%4]);
      chk($sformatf("fd f%0d e%0d", fr, i), frame_done, i == 15);
      if (i == chg_at) begin
        digits = chg_dig;
        dp     = chg_dp;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; digits = 16'h0; dp = 4'h0;
    step();
    step();
    chk("rst an", an_n, 4'hF);
    chk("rst seg", seg_n, 8'hFF);
    chk("rst fd", frame_done, 1'b0);

    // 1234, then ABCD mid-frame, then dp on digit 2 mid-frame
    rst = 1'b0; en = 1'b1; digits = 16'h1234;
    run_frame(1, 8'h99, 8'hB0, 8'hA4, 8'hF9, 6, 16'hABCD, 4'b0000);
    run_frame(2, 8'hA1, 8'hC6, 8'h83, 8'h88, 6, 16'hABCD, 4'b0100);
    run_frame(3, 8'hA1, 8'hC6, 8'h03, 8'h88, 0, 16'h0, 4'h0);

    // Pause mid-slot 1 (count 2); inputs change while paused must not load
    for (int i = 0; i < 6; i++) step();
    en = 1'b0; digits = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("off an %0d", i), an_n, 4'hF);
      chk($sformatf("off seg %0d", i), seg_n, 8'hFF);
      chk($sformatf("off fd %0d", i), frame_done, 1'b0);
    end
    en = 1'b1;
    step();
    chk("res an0", an_n, 4'hD);
    chk("res seg0", seg_n, 8'hC6);
    step();
    chk("res an1", an_n, 4'hF);
    step();
    chk("res an2", an_n, 4'hB);
    chk("res seg2", seg_n, 8'h03);

    // Reset during slot 2
    digits = 16'h0050; dp = 4'b1000; rst = 1'b1;
    step();
    chk("mid rst an", an_n, 4'hF);
    chk("mid rst seg", seg_n, 8'hFF);
    chk("mid rst fd", frame_done, 1'b0);
    rst = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    run_frame(4, 8'hC0, 8'h92, 8'hFF, 8'h7F, 6, 16'h0000, 4'b1000);
    run_frame(5, 8'hC0, 8'hFF, 8'hFF, 8'h7F, 0, 16'h0, 4'h0);
`else
    run_frame(4, 8'hC0, 8'h92, 8'hC0, 8'h40, 6, 16'h0000, 4'b1000);
    run_frame(5, 8'hC0, 8'hC0, 8'hC0, 8'h40, 0, 16'h0, 4'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
